// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a 3-register window on the CPU data port,
// an 8-entry byte FIFO and a serializer that drains it onto tx.
`timescale 1ns/1ps
module mmio_uart_tx #(
  parameter logic [31:0] BASE         = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          DEPTH        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] raddr,
  output logic [31:0] rdata,
  output logic        rhit,
  input  logic        wen,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  output logic        tx
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] ADDR_TXDATA  = BASE;
  localparam logic [31:0] ADDR_STATUS  = BASE + 32'd4;
  localparam logic [31:0] ADDR_DIVISOR = BASE + 32'd8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_reg, state_next;
  logic [15:0]   bit_cnt_reg, bit_cnt_next;
  logic [15:0]   reload_reg, reload_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_data_reg;

  logic [7:0]    fifo_mem [0:DEPTH-1];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;
  logic [15:0]   divisor_reg;
  logic [31:0]   rdata_reg;
  logic          rhit_reg;

  logic          fifo_empty, fifo_full, busy;
  logic          pop, push, wr_txdata, wr_status, wr_divisor, drop;
  logic [31:0]   status_word, rd_word;
  logic          rd_hit;
  logic          unused_wdata_hi;

  assign unused_wdata_hi = ^wdata[31:16];

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(DEPTH));
  assign busy       = (state_reg != IDLE);

  assign wr_txdata  = wen && (waddr == ADDR_TXDATA);
  assign wr_status  = wen && (waddr == ADDR_STATUS);
  assign wr_divisor = wen && (waddr == ADDR_DIVISOR);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push       = wr_txdata && (!fifo_full || pop);
  assign drop       = wr_txdata && !push;

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    reload_next  = reload_reg;
    bit_idx_next = bit_idx_reg;
    pop          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop          = 1'b1;
          state_next   = START;
          reload_next  = divisor_reg - 16'd1;
          bit_cnt_next = divisor_reg - 16'd1;
        end
      end
      START: begin
        if (bit_cnt_reg == '0) begin
          state_next   = DATA;
          bit_cnt_next = reload_reg;
          bit_idx_next = 3'd0;
        end else begin
          bit_cnt_next = bit_cnt_reg - 16'd1;
        end
      end
      DATA: begin
        if (bit_cnt_reg == '0) begin
          bit_cnt_next = reload_reg;
          if (bit_idx_reg == 3'd7) state_next = STOP;
          else                     bit_idx_next = bit_idx_reg + 3'd1;
        end else begin
          bit_cnt_next = bit_cnt_reg - 16'd1;
        end
      end
      STOP: begin
        if (bit_cnt_reg == '0) begin
          if (!fifo_empty) begin
            pop          = 1'b1;
            state_next   = START;
            reload_next  = divisor_reg - 16'd1;
            bit_cnt_next = divisor_reg - 16'd1;
          end else begin
            state_next   = IDLE;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg - 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Decoded from state so tx goes high as soon as reset clears the FSM.
  assign tx = (state_reg == START) ? 1'b0 :
              (state_reg == DATA)  ? shift_data_reg[bit_idx_reg] : 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      reload_reg  <= '0;
      bit_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      reload_reg  <= reload_next;
      bit_idx_reg <= bit_idx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= wdata[7:0];
    if (pop)  shift_data_reg <= fifo_mem[rd_ptr_reg];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push && !pop)      count_reg <= count_reg + CW'(1);
      else if (pop && !push) count_reg <= count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_reg <= 1'b0;
      divisor_reg  <= 16'(CLKS_PER_BIT);
    end else begin
      if (drop)           overflow_reg <= 1'b1;
      else if (wr_status) overflow_reg <= 1'b0;
      if (wr_divisor) divisor_reg <= (wdata[15:0] == '0) ? 16'd1 : wdata[15:0];
    end
  end

  assign status_word = ((32'(count_reg) << 4) |
                        {28'b0, overflow_reg, busy, fifo_empty, fifo_full}) & 32'h0000_00FF;

  always_comb begin
    rd_word = '0;
    rd_hit  = 1'b0;
    if (raddr == ADDR_TXDATA) begin
      rd_hit  = 1'b1;
    end else if (raddr == ADDR_STATUS) begin
      rd_hit  = 1'b1;
      rd_word = status_word;
    end else if (raddr == ADDR_DIVISOR) begin
      rd_hit  = 1'b1;
      rd_word = {16'b0, divisor_reg};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_reg <= '0;
      rhit_reg  <= 1'b0;
    end else begin
      rdata_reg <= rd_word;
      rhit_reg  <= rd_hit;
    end
  end

  assign rdata = rdata_reg;
  assign rhit  = rhit_reg;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register vector table, hand-built frame
// sequences and randomized bursts compared against a frame-level line model.
`timescale 1ns/1ps
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'd4;
  localparam logic [31:0] A_DIV = BASE + 32'd8;
  localparam int DEPTH = 8;
  localparam int HIST  = 16384;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] raddr = '0;
  logic [31:0] rdata;
  logic        rhit;
  logic        wen = 1'b0;
  logic [31:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic        tx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic tx_hist [0:HIST-1];
  logic [7:0] exp_bytes [0:15];
  int         exp_div   [0:15];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    logic        hit;
  } vec_t;
  vec_t vecs [0:17];

  mmio_uart_tx #(.BASE(BASE), .CLKS_PER_BIT(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .rhit(rhit),
    .wen(wen), .waddr(waddr), .wdata(wdata), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < HIST) tx_hist[cyc] = tx;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, got);
    end
  endtask

  task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
    wen = 1'b1; waddr = a; wdata = d;
    @(posedge clk); #1;
    wen = 1'b0; waddr = '0; wdata = '0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d, output logic h);
    raddr = a;
    @(posedge clk); #1;
    d = rdata; h = rhit;
    raddr = '0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a,
                            input logic [31:0] exp, input logic exp_hit);
    logic [31:0] d;
    logic        h;
    read_reg(a, d, h);
    check({name, ".rdata"}, d, exp);
    check({name, ".rhit"}, {31'b0, h}, {31'b0, exp_hit});
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] status_word(input int occ, input bit busy, input bit ovf);
    return (occ << 4) + (ovf ? 8 : 0) + (busy ? 4 : 0) + ((occ == 0) ? 2 : 0) + ((occ == DEPTH) ? 1 : 0);
  endfunction

  // Line level at offset k from the first start bit: frames of 10 slots, each
  // slot one bit period long: start 0, data LSB first, stop 1.
  function automatic logic line_bit(input int k, input int nframes);
    int rem;
    int slot;
    logic [7:0] b;
    rem = k;
    if (k < 0) return 1'b1;
    for (int f = 0; f < nframes; f++) begin
      if (rem < 10 * exp_div[f]) begin
        slot = rem / exp_div[f];
        b = exp_bytes[f];
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return b[slot-1];
      end
      rem -= 10 * exp_div[f];
    end
    return 1'b1;
  endfunction

  task automatic check_line(input string name, input int start, input int nframes);
    int total;
    int bad_at;
    logic g, e, bad_g, bad_e;
    total = 0;
    for (int f = 0; f < nframes; f++) total += 10 * exp_div[f];
    wait_until(start + total + 2);
    bad_at = -2; bad_g = 1'b0; bad_e = 1'b0;
    for (int k = -1; k <= total; k++) begin
      g = tx_hist[start + k];
      e = line_bit(k, nframes);
      if (g !== e && bad_at == -2) begin bad_at = k; bad_g = g; bad_e = e; end
    end
    checks++;
    if (bad_at != -2) begin
      failures++;
      $display("FAIL %s: tx at offset %0d (cycle %0d) got %b expected %b",
               name, bad_at, start + bad_at, bad_g, bad_e);
    end else begin
      $display("ok   %s: %0d frames, %0d cycles", name, nframes, total);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        h;
    int w, n, m, occ, dv;
    bit ovf, pop_m, push_m;
    logic [7:0] b;

    vecs[0]  = '{1'b0, A_DIV,         32'h0,        32'd16, 1'b1};
    vecs[1]  = '{1'b0, A_ST,          32'h0,        32'h02, 1'b1};
    vecs[2]  = '{1'b0, A_TX,          32'h0,        32'h00, 1'b1};
    vecs[3]  = '{1'b0, BASE + 32'd12, 32'h0,        32'h00, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,         32'h0,        32'h00, 1'b0};
    vecs[5]  = '{1'b1, A_DIV,         32'h0,        32'h00, 1'b0};
    vecs[6]  = '{1'b0, A_DIV,         32'h0,        32'd1,  1'b1};
    vecs[7]  = '{1'b1, A_DIV,         32'hABCD0007, 32'h00, 1'b0};
    vecs[8]  = '{1'b0, A_DIV,         32'h0,        32'd7,  1'b1};
    vecs[9]  = '{1'b0, BASE + 32'd2,  32'h0,        32'h00, 1'b0};
    vecs[10] = '{1'b1, A_ST,          32'hFFFFFFFF, 32'h00, 1'b0};
    vecs[11] = '{1'b0, A_ST,          32'h0,        32'h02, 1'b1};
    vecs[12] = '{1'b1, BASE + 32'd12, 32'd5,        32'h00, 1'b0};
    vecs[13] = '{1'b0, A_DIV,         32'h0,        32'd7,  1'b1};
    vecs[14] = '{1'b1, A_DIV,         32'd4,        32'h00, 1'b0};
    vecs[15] = '{1'b0, A_DIV,         32'h0,        32'd4,  1'b1};
    vecs[16] = '{1'b1, 32'h0,         32'h41,       32'h00, 1'b0};
    vecs[17] = '{1'b0, A_ST,          32'h0,        32'h02, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset.tx",    {31'b0, tx},   32'd1);
    check("reset.rhit",  {31'b0, rhit}, 32'd0);
    check("reset.rdata", rdata,         32'd0);
    @(posedge clk); #1 reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].wr) write_reg(vecs[i].addr, vecs[i].data);
      else read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp, vecs[i].hit);
    end

    // Read and write of DIVISOR in one cycle returns the old value
    raddr = A_DIV; wen = 1'b1; waddr = A_DIV; wdata = 32'd9;
    @(posedge clk); #1;
    check("rw_same.rdata", rdata, 32'd4);
    wen = 1'b0; raddr = '0;
    read_check("rw_same.after", A_DIV, 32'd9, 1'b1);
    write_reg(A_DIV, 32'd4);

    // Single 0x55 frame at divisor 4
    write_reg(A_TX, 32'h55);
    w = cyc;
    read_check("f55.status_queued", A_ST, 32'h10, 1'b1);
    read_check("f55.status_busy",   A_ST, 32'h06, 1'b1);
    exp_bytes[0] = 8'h55; exp_div[0] = 4;
    check_line("f55.line", w + 1, 1);

    // Back-to-back frames: no idle gap between stop and next start
    write_reg(A_TX, 32'hA5);
    w = cyc;
    write_reg(A_TX, 32'h3C);
    exp_bytes[0] = 8'hA5; exp_div[0] = 4;
    exp_bytes[1] = 8'h3C; exp_div[1] = 4;
    check_line("b2b.line", w + 1, 2);

    // Divisor change mid-frame applies from the next frame only
    write_reg(A_TX, 32'h96);
    w = cyc;
    write_reg(A_TX, 32'h0F);
    wait_until(w + 9);
    write_reg(A_DIV, 32'd8);
    read_check("divchg.read", A_DIV, 32'd8, 1'b1);
    exp_bytes[0] = 8'h96; exp_div[0] = 4;
    exp_bytes[1] = 8'h0F; exp_div[1] = 8;
    check_line("divchg.line", w + 1, 2);

    // Fill to full, overflow on the 10th write, clear by STATUS write
    write_reg(A_DIV, 32'd16);
    for (int i = 0; i < 10; i++) begin
      write_reg(A_TX, 32'(i * 17 + 3));
      if (i == 0) w = cyc;
      if (i < 9) begin exp_bytes[i] = 8'(i * 17 + 3); exp_div[i] = 16; end
    end
    read_check("ovf.status_set",   A_ST, 32'h8D, 1'b1);
    write_reg(A_ST, 32'h0);
    read_check("ovf.status_clear", A_ST, 32'h85, 1'b1);
    check_line("ovf.line", w + 1, 9);

    // Push in the same cycle as a pop, with DEPTH-1 and DEPTH entries queued
    write_reg(A_DIV, 32'd2);
    for (int fill = DEPTH - 1; fill <= DEPTH; fill++) begin
      for (int i = 0; i <= fill; i++) begin
        b = 8'($urandom_range(0, 255));
        exp_bytes[i] = b; exp_div[i] = 2;
        write_reg(A_TX, {24'b0, b});
        if (i == 0) w = cyc;
      end
      wait_until(w + 20);
      b = 8'($urandom_range(0, 255));
      exp_bytes[fill + 1] = b; exp_div[fill + 1] = 2;
      write_reg(A_TX, {24'b0, b});
      read_check($sformatf("popcoll%0d.status", fill), A_ST, status_word(fill, 1'b1, 1'b0), 1'b1);
      check_line($sformatf("popcoll%0d.line", fill), w + 1, fill + 2);
    end

    // Randomized bursts against the occupancy/line model
    for (int r = 0; r < 5; r++) begin
      dv = $urandom_range(2, 6);
      n  = $urandom_range(1, 11);
      write_reg(A_DIV, 32'(dv));
      occ = 0; m = 0; ovf = 1'b0;
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(0, 255));
        pop_m  = (i >= 1) && ((i - 1) % (10 * dv) == 0) && (occ > 0);
        push_m = (occ < DEPTH) || pop_m;
        if (push_m) begin exp_bytes[m] = b; exp_div[m] = dv; m++; end
        else ovf = 1'b1;
        occ = occ + int'(push_m) - int'(pop_m);
        write_reg(A_TX, {24'b0, b});
        if (i == 0) w = cyc;
      end
      $display("rand%0d: div=%0d writes=%0d accepted=%0d", r, dv, n, m);
      read_check($sformatf("rand%0d.status", r), A_ST, status_word(occ, n >= 2, ovf), 1'b1);
      read_check($sformatf("rand%0d.miss", r), BASE + 32'd12 + 32'($urandom_range(0, 100) * 4), 32'h0, 1'b0);
      if (ovf) write_reg(A_ST, 32'h0);
      check_line($sformatf("rand%0d.line", r), w + 1, m);
      read_check($sformatf("rand%0d.idle", r), A_ST, 32'h02, 1'b1);
    end

    // Reset in the middle of the DATA state
    write_reg(A_DIV, 32'd4);
    write_reg(A_TX, 32'h00);
    w = cyc;
    write_reg(A_TX, 32'h5A);
    write_reg(A_TX, 32'hC3);
    wait_until(w + 10);
    @(negedge clk);
    check("rst_mid.tx_before", {31'b0, tx}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("rst_mid.tx_now",   {31'b0, tx},   32'd1);
    check("rst_mid.rhit_now", {31'b0, rhit}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    read_check("rst_mid.status", A_ST,  32'h02,  1'b1);
    read_check("rst_mid.div",    A_DIV, 32'd16,  1'b1);
    repeat (3) @(posedge clk);
    #1 check("rst_mid.tx_idle", {31'b0, tx}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
